// File: rtl/operand_loader_pkg.sv
// Shared types and constants for the serial operand loader feeding the 4-bit comparator.
package operand_loader_pkg;

    localparam int unsigned CMP_WIDTH = 4;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } ldr_state_t;

endpackage : operand_loader_pkg

// File: rtl/serial_shift_reg.sv
// WIDTH-bit MSB-first serial-in/parallel-out shift register with synchronous clear.
module serial_shift_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;

    // Clear beats shift so an abort never captures the in-flight bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else if (clr) begin
            q_q <= '0;
        end else if (shift_en) begin
            q_q <= {q_q[WIDTH-2:0], din};
        end
    end

    assign q = q_q;

endmodule : serial_shift_reg

// File: rtl/four_bit_operand_loader.sv
// Collects operand a then b serially (MSB first) and presents both with a valid/ready handshake.
module four_bit_operand_loader
    import operand_loader_pkg::*;
#(
    parameter int unsigned WIDTH = CMP_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             sdata,
    input  logic             sval,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    ldr_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overrun_q, overrun_d;
    logic             out_valid_q;
    logic             shift_a, shift_b;
    logic             last_bit;

    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // Next-state, counter and shift-enable decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        shift_a   = 1'b0;
        shift_b   = 1'b0;
        if (clear) begin
            state_d   = LOAD_A;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (sval) begin
                        shift_a = 1'b1;
                        if (last_bit) begin
                            cnt_d   = '0;
                            state_d = LOAD_B;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                LOAD_B: begin
                    if (sval) begin
                        shift_b = 1'b1;
                        if (last_bit) begin
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (sval) begin
                        overrun_d = 1'b1;
                    end
                    if (out_ready) begin
                        state_d = LOAD_A;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // out_valid is registered alongside the state so it is a pure decode of HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= LOAD_A;
            cnt_q       <= '0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
            out_valid_q <= (state_d == HOLD);
        end
    end

    serial_shift_reg #(.WIDTH(WIDTH)) u_shift_a (
        .clk      (clk),
        .rst      (rst),
        .clr      (clear),
        .shift_en (shift_a),
        .din      (sdata),
        .q        (a)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_shift_b (
        .clk      (clk),
        .rst      (rst),
        .clr      (clear),
        .shift_en (shift_b),
        .din      (sdata),
        .q        (b)
    );

    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;

endmodule : four_bit_operand_loader

// File: tb/tb_four_bit_operand_loader.sv
// Directed self-checking bench for four_bit_operand_loader.
module tb_four_bit_operand_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic       sdata = 1'b0;
    logic       sval = 1'b0;
    logic       out_ready = 1'b0;
    logic [3:0] a, b;
    logic       out_valid, overrun;

    int n_cmp = 0;
    int n_bad = 0;

    four_bit_operand_loader #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .sdata     (sdata),
        .sval      (sval),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after a rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] av, input logic [3:0] bv, input bit gap, input string tag);
        logic [7:0] bits;
        bits = {av, bv};
        for (int i = 7; i >= 0; i--) begin
            sdata = bits[i];
            sval  = 1'b1;
            tick();
            sval  = 1'b0;
            if (i == 1) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s early_valid: got %b want 0", tag, out_valid);
                end
            end
            if (gap && i != 0) tick();
        end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL %s valid_after_8: got %b want 1", tag, out_valid);
        end
        n_cmp++;
        if (a !== av || b !== bv) begin
            n_bad++;
            $display("FAIL %s operands: got a=%h b=%h want a=%h b=%h", tag, a, b, av, bv);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        n_cmp++;
        if (a !== 4'h0 || b !== 4'h0 || out_valid !== 1'b0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: got a=%h b=%h v=%b ov=%b want 0 0 0 0", a, b, out_valid, overrun);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        load(4'h3, 4'h4, 1'b0, "basic");
        n_cmp++;
        if (!(a < b)) begin
            n_bad++;
            $display("FAIL basic_less: got a=%h b=%h want a<b", a, b);
        end
        handshake();
        n_cmp++;
        if (out_valid !== 1'b0 || a !== 4'h3 || b !== 4'h4 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_after_hs: got v=%b a=%h b=%h ov=%b want 0 3 4 0", out_valid, a, b, overrun);
        end
    endtask

    task automatic test_gapped();
        load(4'hA, 4'hA, 1'b1, "gapped");
        handshake();
    endtask

    task automatic test_backpressure();
        load(4'h7, 4'h6, 1'b0, "bp");
        for (int c = 0; c < 5; c++) begin
            sval  = (c == 1 || c == 3);
            sdata = 1'b1;
            tick();
            sval  = 1'b0;
            n_cmp++;
            if (a !== 4'h7 || b !== 4'h6 || out_valid !== 1'b1 || overrun !== (c >= 1)) begin
                n_bad++;
                $display("FAIL bp_hold_%0d: got a=%h b=%h v=%b ov=%b want 7 6 1 %b", c, a, b, out_valid, overrun, (c >= 1));
            end
        end
        handshake();
        n_cmp++;
        if (out_valid !== 1'b0 || overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_sticky: got v=%b ov=%b want 0 1", out_valid, overrun);
        end
        load(4'h3, 4'h5, 1'b0, "bp_next");
        handshake();
    endtask

    task automatic test_hs_overrun();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        load(4'h1, 4'h2, 1'b0, "hsov");
        out_ready = 1'b1;
        sval  = 1'b1;
        sdata = 1'b1;
        tick();
        out_ready = 1'b0;
        sval = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || overrun !== 1'b1 || a !== 4'h1 || b !== 4'h2) begin
            n_bad++;
            $display("FAIL hsov_drop: got v=%b ov=%b a=%h b=%h want 0 1 1 2", out_valid, overrun, a, b);
        end
        load(4'hF, 4'hF, 1'b0, "hsov_next");
        handshake();
    endtask

    task automatic test_clear();
        for (int i = 0; i < 5; i++) begin
            sdata = i[0];
            sval  = 1'b1;
            tick();
        end
        clear = 1'b1;
        sdata = 1'b1;
        tick();
        clear = 1'b0;
        sval  = 1'b0;
        n_cmp++;
        if (a !== 4'h0 || b !== 4'h0 || overrun !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clear_state: got a=%h b=%h ov=%b v=%b want 0 0 0 0", a, b, overrun, out_valid);
        end
        load(4'h9, 4'hA, 1'b0, "clear_next");
        handshake();
    endtask

    task automatic test_async_reset();
        load(4'h2, 4'hC, 1'b0, "arst");
        sval = 1'b1;
        tick();
        sval = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || a !== 4'h0 || b !== 4'h0 || overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL arst_immediate: got v=%b a=%h b=%h ov=%b want 0 0 0 0", out_valid, a, b, overrun);
        end
        tick();
        rst = 1'b0;
        load(4'h5, 4'h6, 1'b0, "arst_next");
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure();
        test_hs_overrun();
        test_clear();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_four_bit_operand_loader

// File: doc/four_bit_operand_loader.md
# four_bit_operand_loader

Serial-to-parallel operand front end for the 4-bit magnitude comparator. It collects operand `a` and then operand `b` one bit at a time, MSB first, from a serial strobe interface. It presents both operands in parallel with a valid/ready handshake, holding them stable until the consumer accepts. Its `a`/`b` outputs drive the comparator's `a`/`b` inputs directly; the comparator's `equal`/`greater`/`less` are meaningful while `out_valid` is high.

## Interface
- `WIDTH`, default 4: operand width in bits. Must be ≥ 2; the comparator stage requires 4.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `clear` in 1: synchronous abort/restart; highest priority after `rst`.
- `sdata` in 1: serial data bit.
- `sval` in 1: `sdata` is valid this cycle. One bit is accepted per cycle with `sval` high.
- `a` out WIDTH: operand A register.
- `b` out WIDTH: operand B register.
- `out_valid` out 1: `a`/`b` complete and stable.
- `out_ready` in 1: consumer accepts `a`/`b`.
- `overrun` out 1: sticky; a serial bit was dropped.

## Operation
- States:
  - LOAD_A (reset state).
  - LOAD_B.
  - HOLD.
- Bit counter `cnt`, width clog2(WIDTH), counts accepted bits within the current operand.
- LOAD_A, `sval`=1:
  - `a <= {a[WIDTH-2:0], sdata}`; `cnt++`.
  - If `cnt==WIDTH-1`: `cnt<=0`, go to LOAD_B.
- LOAD_B, `sval`=1:
  - Same shift into `b`.
  - On the last bit: `cnt<=0`, go to HOLD.
- HOLD:
  - `out_valid`=1; `a`/`b` frozen.
  - `out_ready`=1 completes the handshake: next state LOAD_A.
  - `sval`=1 in HOLD: bit dropped, `overrun<=1`. This still applies if `out_ready` is high in the same cycle. The next operand starts with the first `sval` after returning to LOAD_A.
- `sval`=0 in a load state: no change. Gaps between bits are allowed, of any length.
- `out_ready` outside HOLD is ignored.
- `a` is not cleared on entry to LOAD_A. After WIDTH bits it is fully overwritten, so old contents shift out.
- `clear`=1, synchronous: state LOAD_A, `cnt`=0, `a`=0, `b`=0, `overrun`=0. `sval` is ignored that cycle.
- `overrun` clears only on `clear` or `rst`.

## Timing
- Reset values:
  - state LOAD_A, `cnt`=0.
  - `a`=0, `b`=0.
  - `out_valid`=0, `overrun`=0.
- `out_valid` is a registered-state decode, equivalent to (state==HOLD). It has no combinational path from `out_ready` or `sval`.
- Latency: if the 2·WIDTH-th accepted bit is sampled at edge N, `out_valid`=1 from just after edge N.
- Minimum load time: 2·WIDTH cycles. Minimum period between transactions: 2·WIDTH+1 cycles (one HOLD cycle).
- Handshake at edge M (`out_valid`=1 and `out_ready`=1): `out_valid`=0 after M. `a`/`b` keep their values until the next accepted bit.
- `rst` mid-load or in HOLD: immediate return to reset values. The partial operand is discarded.
- `clear` and a handshake in the same cycle: `clear` wins; the result is the same end state.

## Structure
- Shared package `operand_loader_pkg` holds:
  - state enum `ldr_state_t` {LOAD_A, LOAD_B, HOLD}.
  - localparam `CMP_WIDTH = 4`.
- One natural sub-module: `serial_shift_reg`, a WIDTH-bit MSB-first shift register with `shift_en` and synchronous `clr`. It is instantiated twice, for `a` and for `b`, with enables gated by state.
- FSM and counter live in the top module.

## Test plan
- Reset then load: after `rst`, send 0011 then 0100 with `sval` continuously high. Required: `out_valid`=1 on the cycle after the 8th bit, `a`=4'h3, `b`=4'h4 (comparator shows `less`=1). Assert `out_ready` → `out_valid`=0 next cycle.
- Gapped stream: send 1010 then 1010 with `sval` toggling 1/0. Required: `a`=`b`=4'hA, `out_valid` only after the 8th accepted bit, `equal`=1.
- Backpressure: load 0111/0110, hold `out_ready`=0 for 5 cycles while pulsing `sval` twice. Required: `a`=4'h7, `b`=4'h6 stable, `overrun`=1 and sticky after the handshake, next transaction loads cleanly.
- Handshake plus `sval` in the same HOLD cycle: the bit is dropped and `overrun`=1. Loading then 1111/1111 gives `a`=`b`=4'hF.
- Mid-operation abort: after 5 bits, pulse `clear`. Required: `a`=`b`=0, state LOAD_A, `overrun`=0. A subsequent full 1001/1010 load gives `a`=4'h9, `b`=4'hA.
- Async reset: assert `rst` between clock edges while in HOLD. Required: `out_valid` falls immediately without waiting for an edge; all outputs are at reset values.
